// File: rtl/bsq_pkg.sv
// Shared helpers for the bit stream queue: default geometry, derived-width
// functions, the default count type and an elaboration-time parameter check.
`ifndef BSQ_PKG_SV
`define BSQ_PKG_SV

`define BSQ_PARAM_CHECK(cond_, msg_) \
    if (!(cond_)) begin : g_bsq_param_check \
        $error(msg_); \
    end

package bsq_pkg;
    localparam int BSQ_IN_WIDTH_DEF  = 64;
    localparam int BSQ_OUT_WIDTH_DEF = 128;
    localparam int BSQ_BUF_WIDTH_DEF = 512;

    // counts span 0..buf_width inclusive, pointers span 0..buf_width-1
    function automatic int bsq_cnt_w(input int buf_width);
        return $clog2(buf_width + 1);
    endfunction

    function automatic int bsq_ptr_w(input int buf_width);
        return $clog2(buf_width);
    endfunction

    localparam int BSQ_CNT_W_DEF = bsq_cnt_w(BSQ_BUF_WIDTH_DEF);

    typedef logic [BSQ_CNT_W_DEF-1:0] count_t;
endpackage

`endif

// File: rtl/bsq_window_extract.sv
// Rotates the storage ring so the head bit lands at window[0]; positions at or
// beyond cnt are forced to zero.
module bsq_window_extract
    import bsq_pkg::*;
#(
    parameter int OUT_WIDTH = BSQ_OUT_WIDTH_DEF,
    parameter int BUF_WIDTH = BSQ_BUF_WIDTH_DEF,
    parameter int CNT_W     = bsq_cnt_w(BUF_WIDTH),
    parameter int PTR_W     = bsq_ptr_w(BUF_WIDTH)
) (
    input  logic [BUF_WIDTH-1:0] ring,
    input  logic [PTR_W-1:0]     head,
    input  logic [CNT_W-1:0]     cnt,
    output logic [0:OUT_WIDTH-1] window
);

    for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_win
        localparam logic [PTR_W-1:0] OFF = PTR_W'(k);
        localparam logic [CNT_W-1:0] POS = CNT_W'(k);
        logic [PTR_W-1:0] idx;

        // pointer-width add wraps BUF_WIDTH-1 -> 0 for free
        assign idx       = head + OFF;
        assign window[k] = (POS < cnt) ? ring[idx] : 1'b0;
    end

endmodule

// File: rtl/bit_stream_queue.sv
// Bit-granular FIFO: up to IN_WIDTH bits enqueued per cycle, OUT_WIDTH-bit head
// window presented to the consumer, variable retire count per cycle.
module bit_stream_queue
    import bsq_pkg::*;
#(
    parameter int IN_WIDTH  = BSQ_IN_WIDTH_DEF,
    parameter int OUT_WIDTH = BSQ_OUT_WIDTH_DEF,
    parameter int BUF_WIDTH = BSQ_BUF_WIDTH_DEF,
    parameter int CNT_W     = bsq_cnt_w(BUF_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [CNT_W-1:0]     in_cnt,
    input  logic [0:IN_WIDTH-1]  in_data,
    output logic                 in_ready,
    input  logic [CNT_W-1:0]     deq_cnt,
    output logic [CNT_W-1:0]     out_cnt,
    output logic [0:OUT_WIDTH-1] out_data,
    output logic [CNT_W-1:0]     occupancy,
    output logic                 overrun
);

    localparam int PTR_W = bsq_ptr_w(BUF_WIDTH);
    localparam int IDX_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] IN_MAX  = CNT_W'(IN_WIDTH);
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0] BUF_MAX = CNT_W'(BUF_WIDTH);

    `BSQ_PARAM_CHECK((BUF_WIDTH >= IN_WIDTH + OUT_WIDTH) && ((BUF_WIDTH & (BUF_WIDTH - 1)) == 0),
                     "bit_stream_queue: BUF_WIDTH must be a power of two >= IN_WIDTH + OUT_WIDTH")

    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     occ_q;
    logic [BUF_WIDTH-1:0] buf_q;
    logic                 overrun_q;

    logic [CNT_W-1:0]     free_bits;
    logic                 in_fire;
    logic [CNT_W-1:0]     in_eff;
    logic [CNT_W-1:0]     in_add;
    logic [CNT_W-1:0]     out_cnt_w;
    logic [CNT_W-1:0]     deq_eff;
    logic                 overrun_evt;
    logic [BUF_WIDTH-1:0] wr_en;
    logic [BUF_WIDTH-1:0] wr_bit;

    assign free_bits   = BUF_MAX - occ_q;
    assign in_ready    = (free_bits >= IN_MAX);
    assign in_fire     = in_valid && in_ready;
    assign in_eff      = (in_cnt > IN_MAX) ? IN_MAX : in_cnt;
    assign in_add      = in_fire ? in_eff : '0;
    assign out_cnt_w   = (occ_q > OUT_MAX) ? OUT_MAX : occ_q;
    assign deq_eff     = (deq_cnt > out_cnt_w) ? out_cnt_w : deq_cnt;
    assign overrun_evt = (deq_cnt > out_cnt_w) || (in_valid && (in_cnt > IN_MAX));

    // Each storage bit decides for itself whether it lies in [tail, tail+in_eff)
    for (genvar i = 0; i < BUF_WIDTH; i++) begin : g_wr
        logic [PTR_W-1:0] off;

        assign off       = PTR_W'(i) - tail_q;
        assign wr_en[i]  = CNT_W'(off) < in_add;
        assign wr_bit[i] = in_data[off[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            for (int i = 0; i < BUF_WIDTH; i++) begin
                if (wr_en[i]) begin
                    buf_q[i] <= wr_bit[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            overrun_q <= 1'b0;
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q    <= head_q + deq_eff[PTR_W-1:0];
            tail_q    <= tail_q + in_add[PTR_W-1:0];
            occ_q     <= occ_q + in_add - deq_eff;
            overrun_q <= overrun_q | overrun_evt;
        end
    end

    bsq_window_extract #(
        .OUT_WIDTH (OUT_WIDTH),
        .BUF_WIDTH (BUF_WIDTH),
        .CNT_W     (CNT_W),
        .PTR_W     (PTR_W)
    ) u_window (
        .ring   (buf_q),
        .head   (head_q),
        .cnt    (out_cnt_w),
        .window (out_data)
    );

    assign out_cnt   = out_cnt_w;
    assign occupancy = occ_q;
    assign overrun   = overrun_q;

endmodule
